// File: rtl/bram4x128_fifo_ctrl_if.sv
// rtl/bram4x128_fifo_ctrl_if.sv - valid/ready input and output streams of the bram4x128 FIFO controller
// The FIFO controller connects through the slave modport. The producer/consumer side connects through master.
interface bram4x128_fifo_ctrl_if #(
   parameter int DW = 128
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;

   modport slave (
      input  s_valid,
      input  s_data,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_data
   );

   modport master (
      output s_valid,
      output s_data,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_data
   );
endinterface

// File: rtl/bram4x128_fifo_ctrl.sv
// rtl/bram4x128_fifo_ctrl.sv - stream FIFO staged through the single port of a bram4x128
// The controller interleaves writes and reads on one RAM port. A 2-entry buffer absorbs the one-cycle read latency.
module bram4x128_fifo_ctrl #(
   parameter int DW = 128,
   parameter int WL = 4,
   parameter int AW = 13,
   parameter int PW = 2
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  clr,
   bram4x128_fifo_ctrl_if.slave  bus,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [AW-1:0]         ram_a,
   output logic [DW-1:0]         ram_di,
   input  logic [DW-1:0]         ram_do,
   output logic [PW+1:0]         level
);

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;

   localparam logic [PW:0] FULL_CNT = WL[PW:0];

   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic          rd_inflight_q, rd_inflight_d;
   op_e           last_op_q, last_op_d;
   logic          ram_en_q, ram_en_d;
   logic [AW-1:0] ram_a_q, ram_a_d;
   logic [DW-1:0] ob_mem_q [2];
   logic [DW-1:0] ob_mem_d [2];
   logic          ob_rd_q, ob_rd_d;
   logic          ob_wr_q, ob_wr_d;
   logic [1:0]    ob_cnt_q, ob_cnt_d;
   logic [PW+1:0] level_q, level_d;

   logic [PW:0]   ram_cnt;
   logic [PW:0]   ram_cnt_d;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic [2:0]    ob_after;
   logic          want_rd;
   logic          want_wr;
   logic          do_rd;
   logic          do_wr;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   always_comb begin
      ram_cnt = wr_ptr_q - rd_ptr_q;
      full    = (ram_cnt == FULL_CNT);
      empty   = (ram_cnt == '0);
      pop     = (ob_cnt_q != 2'd0) && bus.m_ready;
      push    = rd_inflight_q && !clr;
      wr_addr = {{(AW-PW-2){1'b0}}, wr_ptr_q[PW-1:0], 2'b00};
      rd_addr = {{(AW-PW-2){1'b0}}, rd_ptr_q[PW-1:0], 2'b00};

      // A read may only be issued if its data will still find a free buffer slot when it lands.
      ob_after = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
      want_rd  = !empty && (ob_after < 3'd2) && !clr;
      want_wr  = bus.s_valid && !full && ram_en_q && !clr;

      do_rd = want_rd && (!want_wr || (last_op_q == OP_WRITE));
      do_wr = want_wr && (!want_rd || (last_op_q == OP_READ));
   end

   // s_ready is derived without s_valid: a pending read blocks the port unless it is the write's turn.
   assign bus.s_ready = ram_en_q && !full && !clr && (!want_rd || (last_op_q == OP_READ));
   assign bus.m_valid = (ob_cnt_q != 2'd0);
   assign bus.m_data  = ob_mem_q[ob_rd_q];

   assign ram_en = ram_en_q;
   assign ram_we = do_wr ? 4'hF : 4'h0;
   assign ram_a  = do_wr ? wr_addr : (do_rd ? rd_addr : ram_a_q);
   assign ram_di = do_wr ? bus.s_data : '0;
   assign level  = level_q;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      rd_inflight_d = 1'b0;
      last_op_d     = last_op_q;
      ram_en_d      = 1'b1;
      ram_a_d       = ram_a_q;
      ob_mem_d      = ob_mem_q;
      ob_rd_d       = ob_rd_q;
      ob_wr_d       = ob_wr_q;
      ob_cnt_d      = ob_cnt_q;

      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ob_rd_d  = 1'b0;
         ob_wr_d  = 1'b0;
         ob_cnt_d = 2'd0;
      end else begin
         if (do_wr) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            last_op_d = OP_WRITE;
            ram_a_d   = wr_addr;
         end
         if (do_rd) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            rd_inflight_d = 1'b1;
            last_op_d     = OP_READ;
            ram_a_d       = rd_addr;
         end
         if (push) begin
            ob_mem_d[ob_wr_q] = ram_do;
            ob_wr_d           = !ob_wr_q;
         end
         if (pop) begin
            ob_rd_d = !ob_rd_q;
         end
         ob_cnt_d = ob_cnt_q + {1'b0, push} - {1'b0, pop};
      end

      ram_cnt_d = wr_ptr_d - rd_ptr_d;
      level_d   = {1'b0, ram_cnt_d} + {{(PW+1){1'b0}}, rd_inflight_d} + {{PW{1'b0}}, ob_cnt_d};
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         rd_inflight_q <= 1'b0;
         last_op_q     <= OP_WRITE;
         ram_en_q      <= 1'b0;
         ram_a_q       <= '0;
         ob_mem_q[0]   <= '0;
         ob_mem_q[1]   <= '0;
         ob_rd_q       <= 1'b0;
         ob_wr_q       <= 1'b0;
         ob_cnt_q      <= 2'd0;
         level_q       <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         rd_inflight_q <= rd_inflight_d;
         last_op_q     <= last_op_d;
         ram_en_q      <= ram_en_d;
         ram_a_q       <= ram_a_d;
         ob_mem_q[0]   <= ob_mem_d[0];
         ob_mem_q[1]   <= ob_mem_d[1];
         ob_rd_q       <= ob_rd_d;
         ob_wr_q       <= ob_wr_d;
         ob_cnt_q      <= ob_cnt_d;
         level_q       <= level_d;
      end
   end

endmodule
